ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline. Sits directly downstream of the ALU control decoder and consumes its 5-bit ALU_Ctrl code plus the ID/EX operands.
- Performs the ALU operation and resolves branches and JALR, driving a same-cycle PC redirect.
- Registers the result and the control sideband into the EX/MEM pipeline register, which feeds the MEM stage.

---
 rtl/ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage RV32I pipeline.
//
// Performs the ALU operation selected by the 5-bit code from the ALU control
// decoder, resolves branches and JALR into a same-cycle PC redirect, and
// registers the result plus control sideband into the EX/MEM register.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   valid_in              ID/EX slot holds a real instruction
//   alu_ctrl              operation code (0..17 defined, others give 0)
//   src1, src2            forwarded operands (src2 already imm-muxed)
//   pc_in, imm            instruction PC and branch offset
//   rs2_data              store data, passed to MEM
//   rd_in, reg_write_in, mem_read_in, mem_write_in, funct3_in
//                         control sideband, registered into EX/MEM
//   stall, flush          hold / bubble the EX/MEM register (flush wins)
//   redirect, redirect_pc combinational PC redirect (taken branch or JALR)
//   exm_*                 EX/MEM pipeline register outputs
//
// Optional feature (macro EX_BRANCH_STATS_EN):
//   br_count, br_taken_count  32-bit wrapping counters of executed and taken
//                             conditional branches (JALR not counted).
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [4:0]           alu_ctrl,
  input  logic [XLEN-1:0]      src1,
  input  logic [XLEN-1:0]      src2,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [REGADDR_W-1:0] rd_in,
  input  logic                 reg_write_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           funct3_in,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 exm_valid,
  output logic [XLEN-1:0]      exm_alu_out,
  output logic [XLEN-1:0]      exm_rs2_data,
  output logic [REGADDR_W-1:0] exm_rd,
  output logic                 exm_reg_write,
  output logic                 exm_mem_read,
  output logic                 exm_mem_write,
  output logic [2:0]           exm_funct3
`ifdef EX_BRANCH_STATS_EN
  ,
  output logic [31:0]          br_count,
  output logic [31:0]          br_taken_count
`endif
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_JALR = 5'd10;
  localparam logic [4:0] OP_BEQ  = 5'd11;
  localparam logic [4:0] OP_BNE  = 5'd12;
  localparam logic [4:0] OP_BLT  = 5'd13;
  localparam logic [4:0] OP_BGE  = 5'd14;
  localparam logic [4:0] OP_BLTU = 5'd15;
  localparam logic [4:0] OP_BGEU = 5'd16;
  localparam logic [4:0] OP_IMM  = 5'd17;

  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] target;
  logic            is_branch;
  logic            is_jalr;
  logic            cond;

  assign shamt       = src2[4:0];
  assign lt_s        = $signed(src1) < $signed(src2);
  assign lt_u        = src1 < src2;
  assign eq          = src1 == src2;
  assign sum         = src1 + src2;
  assign pc_plus4    = pc_in + XLEN'(4);
  assign br_target   = pc_in + imm;
  // JALR clears bit 0 of the computed target.
  assign jalr_target = {sum[XLEN-1:1], 1'b0};

  always_comb begin
    result    = '0;
    target    = br_target;
    is_branch = 1'b0;
    is_jalr   = 1'b0;
    cond      = 1'b0;
    case (alu_ctrl)
      OP_ADD:  result = sum;
      OP_SUB:  result = src1 - src2;
      OP_SLL:  result = src1 << shamt;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  result = src1 ^ src2;
      OP_SRL:  result = src1 >> shamt;
      OP_SRA:  result = $signed(src1) >>> shamt;
      OP_OR:   result = src1 | src2;
      OP_AND:  result = src1 & src2;
      OP_JALR: begin
        result  = pc_plus4;
        target  = jalr_target;
        is_jalr = 1'b1;
      end
      OP_BEQ:  begin is_branch = 1'b1; cond = eq;    end
      OP_BNE:  begin is_branch = 1'b1; cond = !eq;   end
      OP_BLT:  begin is_branch = 1'b1; cond = lt_s;  end
      OP_BGE:  begin is_branch = 1'b1; cond = !lt_s; end
      OP_BLTU: begin is_branch = 1'b1; cond = lt_u;  end
      OP_BGEU: begin is_branch = 1'b1; cond = !lt_u; end
      OP_IMM:  result = src2;
      default: result = '0;
    endcase
  end

  // A stalled slot must not redirect: it will be re-presented next cycle.
  assign redirect    = valid_in & ~stall & (is_jalr | (is_branch & cond));
  assign redirect_pc = redirect ? target : '0;

  // EX/MEM register. Control bits are qualified by valid_in so an empty slot
  // travels down as a bubble; branches never write back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid     <= 1'b0;
      exm_alu_out   <= '0;
      exm_rs2_data  <= '0;
      exm_rd        <= '0;
      exm_reg_write <= 1'b0;
      exm_mem_read  <= 1'b0;
      exm_mem_write <= 1'b0;
      exm_funct3    <= '0;
    end else if (flush) begin
      exm_valid     <= 1'b0;
      exm_alu_out   <= '0;
      exm_rs2_data  <= '0;
      exm_rd        <= '0;
      exm_reg_write <= 1'b0;
      exm_mem_read  <= 1'b0;
      exm_mem_write <= 1'b0;
      exm_funct3    <= '0;
    end else if (!stall) begin
      exm_valid     <= valid_in;
      exm_alu_out   <= result;
      exm_rs2_data  <= rs2_data;
      exm_rd        <= rd_in;
      exm_reg_write <= valid_in & reg_write_in & ~is_branch;
      exm_mem_read  <= valid_in & mem_read_in;
      exm_mem_write <= valid_in & mem_write_in;
      exm_funct3    <= funct3_in;
    end
  end

`ifdef EX_BRANCH_STATS_EN
  logic br_event;
  assign br_event = is_branch & valid_in & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if (br_event) begin
      br_count <= br_count + 32'd1;
      if (redirect) begin
        br_taken_count <= br_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later and registered outputs 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [4:0]  alu_ctrl;
  logic [31:0] src1, src2, pc_in, imm, rs2_data;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic        stall, flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exm_valid;
  logic [31:0] exm_alu_out, exm_rs2_data;
  logic [4:0]  exm_rd;
  logic        exm_reg_write, exm_mem_read, exm_mem_write;
  logic [2:0]  exm_funct3;
`ifdef EX_BRANCH_STATS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  ex_stage #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_ctrl(alu_ctrl),
    .src1(src1), .src2(src2), .pc_in(pc_in), .imm(imm), .rs2_data(rs2_data),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .funct3_in(funct3_in), .stall(stall),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .exm_valid(exm_valid), .exm_alu_out(exm_alu_out),
    .exm_rs2_data(exm_rs2_data), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_mem_write(exm_mem_write), .exm_funct3(exm_funct3)
`ifdef EX_BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU sweep vectors: code, src1, src2, expected result.
  logic [4:0]  av_op  [12] = '{5'd0, 5'd1, 5'd7, 5'd3, 5'd4, 5'd2,
                               5'd6, 5'd5, 5'd8, 5'd9, 5'd17, 5'd20};
  logic [31:0] av_a   [12] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h0000F0F0,
                               32'hF0, 32'hF0, 32'h1234, 32'd5};
  logic [31:0] av_b   [12] = '{32'd1, 32'd7, 32'd4, 32'd1, 32'd1, 32'h23,
                               32'd31, 32'h0000FF00, 32'h0F, 32'h3C,
                               32'hABCDE000, 32'd6};
  logic [31:0] av_exp [12] = '{32'h0, 32'hFFFFFFFE, 32'hF8000000, 32'd1, 32'd0,
                               32'd8, 32'd1, 32'h00000FF0, 32'hFF, 32'h30,
                               32'hABCDE000, 32'h0};

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im);
    valid_in = v;
    alu_ctrl = op;
    src1     = a;
    src2     = b;
    pc_in    = p;
    imm      = im;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd_in = 5'd3; reg_write_in = 1'b1; rs2_data = 32'h55;
    drive(1'b1, 5'd0, 32'd2, 32'd3, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (exm_valid !== 1'b1) begin failures++; $display("[TB] FAIL reset_pre_valid got=%0h exp=1", exm_valid); end
    checks++; if (exm_alu_out !== 32'd5) begin failures++; $display("[TB] FAIL reset_pre_alu got=%0h exp=5", exm_alu_out); end
    #2;
    rst_n = 1'b0;
    drive(1'b0, 5'd10, 32'h203, 32'h4, 32'h50, 32'h0);
    #1;
    checks++; if (exm_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0h exp=0", exm_valid); end
    checks++; if (exm_alu_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_alu got=%0h exp=0", exm_alu_out); end
    checks++; if ({exm_rd, exm_reg_write, exm_rs2_data} !== 38'h0) begin failures++; $display("[TB] FAIL reset_fields got=%0h/%0h/%0h exp=0", exm_rd, exm_reg_write, exm_rs2_data); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("[TB] FAIL reset_redirect got=%0h exp=0", redirect); end
    // Release in mid-stream: first edge after release loads normally.
    drive(1'b1, 5'd0, 32'd7, 32'd8, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (exm_alu_out !== 32'd15 || exm_valid !== 1'b1) begin failures++; $display("[TB] FAIL reset_release got=%0h/%0h exp=f/1", exm_alu_out, exm_valid); end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, av_op[i], av_a[i], av_b[i], 32'h0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (exm_alu_out !== av_exp[i]) begin
        failures++;
        $display("[TB] FAIL alu[%0d] op=%0d got=%h exp=%h", i, av_op[i], exm_alu_out, av_exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    // BEQ taken
    @(negedge clk);
    reg_write_in = 1'b1;
    drive(1'b1, 5'd11, 32'd3, 32'd3, 32'h100, 32'h20);
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin failures++; $display("[TB] FAIL beq_redirect got=%0h/%h exp=1/00000120", redirect, redirect_pc); end
    @(posedge clk); #1;
    checks++; if (exm_reg_write !== 1'b0 || exm_alu_out !== 32'h0 || exm_valid !== 1'b1) begin failures++; $display("[TB] FAIL beq_regs got=rw%0h alu%h v%0h exp=rw0 alu0 v1", exm_reg_write, exm_alu_out, exm_valid); end
    // BLTU unsigned: 0xFFFFFFFF < 1 is false
    @(negedge clk);
    drive(1'b1, 5'd15, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20);
    #1;
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("[TB] FAIL bltu_redirect got=%0h/%h exp=0/0", redirect, redirect_pc); end
    // BGE -1,-1 taken, negative offset
    @(negedge clk);
    drive(1'b1, 5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h200, 32'hFFFFFFF0);
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h1F0) begin failures++; $display("[TB] FAIL bge_redirect got=%0h/%h exp=1/000001f0", redirect, redirect_pc); end
    // BLT signed -1 < 1 taken
    @(negedge clk);
    drive(1'b1, 5'd13, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h8);
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h48) begin failures++; $display("[TB] FAIL blt_redirect got=%0h/%h exp=1/00000048", redirect, redirect_pc); end
    // BNE equal -> not taken
    @(negedge clk);
    drive(1'b1, 5'd12, 32'd9, 32'd9, 32'h40, 32'h8);
    #1;
    checks++; if (redirect !== 1'b0) begin failures++; $display("[TB] FAIL bne_redirect got=%0h exp=0", redirect); end
    // BGEU 1 >= 0xFFFFFFFF false
    @(negedge clk);
    drive(1'b1, 5'd16, 32'd1, 32'hFFFFFFFF, 32'h40, 32'h8);
    #1;
    checks++; if (redirect !== 1'b0) begin failures++; $display("[TB] FAIL bgeu_redirect got=%0h exp=0", redirect); end
  endtask

  task automatic test_jalr();
    @(negedge clk);
    rd_in = 5'd5; reg_write_in = 1'b1;
    drive(1'b1, 5'd10, 32'h203, 32'h4, 32'h50, 32'h0);
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h206) begin failures++; $display("[TB] FAIL jalr_redirect got=%0h/%h exp=1/00000206", redirect, redirect_pc); end
    @(posedge clk); #1;
    checks++; if (exm_alu_out !== 32'h54 || exm_reg_write !== 1'b1 || exm_rd !== 5'd5) begin failures++; $display("[TB] FAIL jalr_regs got=%h/%0h/%0d exp=00000054/1/5", exm_alu_out, exm_reg_write, exm_rd); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    rd_in = 5'd7; reg_write_in = 1'b0; mem_write_in = 1'b1;
    rs2_data = 32'hDEAD; funct3_in = 3'd2;
    drive(1'b1, 5'd0, 32'd10, 32'd20, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (exm_alu_out !== 32'd30 || exm_mem_write !== 1'b1 || exm_funct3 !== 3'd2) begin failures++; $display("[TB] FAIL stall_load got=%h/%0h/%0h exp=0000001e/1/2", exm_alu_out, exm_mem_write, exm_funct3); end
    // Stall with a JALR presented: no redirect, register holds.
    @(negedge clk);
    stall = 1'b1; rd_in = 5'd9; mem_write_in = 1'b0; rs2_data = 32'h1;
    drive(1'b1, 5'd10, 32'h300, 32'h0, 32'h80, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (redirect !== 1'b0) begin failures++; $display("[TB] FAIL stall_redirect[%0d] got=%0h exp=0", c, redirect); end
      @(posedge clk); #1;
      checks++; if (exm_alu_out !== 32'd30 || exm_rd !== 5'd7 || exm_rs2_data !== 32'hDEAD || exm_mem_write !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold[%0d] got=%h/%0d/%h/%0h exp=0000001e/7/0000dead/1", c, exm_alu_out, exm_rd, exm_rs2_data, exm_mem_write); end
      @(negedge clk);
    end
    // stall and flush together: flush wins.
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (exm_valid !== 1'b0 || exm_alu_out !== 32'h0 || exm_mem_write !== 1'b0) begin failures++; $display("[TB] FAIL stall_flush got=%0h/%h/%0h exp=0/0/0", exm_valid, exm_alu_out, exm_mem_write); end
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    // Invalid slot carrying write/read enables becomes a bubble.
    reg_write_in = 1'b1; mem_read_in = 1'b1;
    drive(1'b0, 5'd0, 32'd1, 32'd1, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (exm_reg_write !== 1'b0 || exm_mem_read !== 1'b0 || exm_valid !== 1'b0) begin failures++; $display("[TB] FAIL bubble got=%0h/%0h/%0h exp=0/0/0", exm_reg_write, exm_mem_read, exm_valid); end
    @(negedge clk);
    mem_read_in = 1'b0;
  endtask

`ifdef EX_BRANCH_STATS_EN
  task automatic test_branch_stats();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    checks++; if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin failures++; $display("[TB] FAIL stats_reset got=%0d/%0d exp=0/0", br_count, br_taken_count); end
    drive(1'b1, 5'd11, 32'd3, 32'd3, 32'h0, 32'h4);   // BEQ taken
    @(negedge clk);
    drive(1'b1, 5'd12, 32'd3, 32'd3, 32'h0, 32'h4);   // BNE not taken
    @(negedge clk);
    stall = 1'b1;
    drive(1'b1, 5'd11, 32'd3, 32'd3, 32'h0, 32'h4);   // stalled, not counted
    @(negedge clk);
    stall = 1'b0;
    drive(1'b1, 5'd15, 32'd1, 32'd2, 32'h0, 32'h4);   // BLTU taken
    @(negedge clk);
    drive(1'b1, 5'd10, 32'd0, 32'd0, 32'h0, 32'h0);   // JALR not counted
    @(negedge clk);
    drive(1'b1, 5'd16, 32'd1, 32'd2, 32'h0, 32'h4);   // BGEU not taken
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0);
    checks++; if (br_count !== 32'd4) begin failures++; $display("[TB] FAIL stats_br_count got=%0d exp=4", br_count); end
    checks++; if (br_taken_count !== 32'd2) begin failures++; $display("[TB] FAIL stats_taken got=%0d exp=2", br_taken_count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rd_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = '0; rs2_data = '0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_stall_flush();
`ifdef EX_BRANCH_STATS_EN
    test_branch_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
